lock_key_arb: RTL and testbench
===============================

Name: lock_key_arb

Overview:
- Multi-channel successor to the single-FIFO lock acquirer.
- Serves NUM_CHANNELS lock-request FIFOs round-robin against one shared lock-unit port, extracting a parametrised key field from each entry.
- Retries blocked keys with a fixed backoff, up to a bounded retry count.
- Forwards each entry to a shared lock-read FIFO, tagged with its channel index and a fail flag. Sits between the per-core request generators and the lock table.

Parameters:
- NUM_CHANNELS, 4, number of request FIFOs (>=1)
- ENTRY_WIDTH, 65, width of one request-FIFO entry
- KEY_LSB, 32, lowest bit of the key field in an entry
- KEY_WIDTH, 32, key field width; KEY_LSB+KEY_WIDTH <= ENTRY_WIDTH
- WAIT_CYCLES, 20, backoff cycles after a blocked attempt (>=1)
- MAX_RETRIES, 7, retries after the first block before giving up; 0 = unlimited
- CH_W, derived, max(1, log2(NUM_CHANNELS)); OUT_WIDTH = ENTRY_WIDTH+1+CH_W

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- gen_lock_fifo_q  in  NUM_CHANNELS*ENTRY_WIDTH  per-channel FIFO data; channel i occupies bits [i*ENTRY_WIDTH +: ENTRY_WIDTH]
- gen_lock_fifo_empty  in  NUM_CHANNELS  per-channel empty
- gen_lock_fifo_rdreq  out  NUM_CHANNELS  one-hot read request
- lock_read_fifo_data  out  OUT_WIDTH  output word {fail, channel, entry}, with fail as the MSB
- lock_read_fifo_full  in  1  output FIFO full
- lock_read_fifo_wrreq  out  1  output write
- proc_key  out  KEY_WIDTH  key presented to lock unit
- proc_obtain_key  out  1  acquire request
- proc_key_grant  in  1  lock granted
- proc_key_blocked  in  1  lock held elsewhere
- locks_available  in  1  lock unit has a free slot

Behaviour:
- Reset (reset=0, asynchronous) clears state to IDLE and zeroes all outputs, rr pointer, timer, retry count and captured entry. A reset mid-operation abandons the request with no further handshake; lock ownership is not tracked by this block.
- All outputs are registered. gen_lock_fifo_rdreq and lock_read_fifo_wrreq are single-cycle pulses.
- Arbitration: the rr pointer starts at 0. In IDLE, the block picks the first non-empty channel at or after the pointer, wrapping modulo NUM_CHANNELS. After the pick, the pointer becomes picked+1, wrapping from NUM_CHANNELS-1 to 0. If no channel is non-empty or locks_available=0, the block stays in IDLE.
- States IDLE, READ_FIFO, PARSE, WAIT_ACQ, WRITE_OUT, WAIT_RETRY.
- Timing: cycle T is IDLE with a pick made.
  - T+1: rdreq[ch]=1, state READ_FIFO.
  - T+2: state PARSE; the entry is captured from slice ch, which the FIFO presents non-show-ahead.
  - T+3: proc_key = entry[KEY_LSB +: KEY_WIDTH], proc_obtain_key=1, state WAIT_ACQ.
- WAIT_ACQ:
  - Grant: proc_obtain_key drops next cycle, retry count clears, go to WRITE_OUT with fail=0. Grant and blocked asserted together count as grant.
  - Blocked with retries remaining: proc_obtain_key drops, timer loads WAIT_CYCLES, retry count increments, go to WAIT_RETRY.
  - Blocked with retries exhausted (count == MAX_RETRIES, MAX_RETRIES != 0): proc_obtain_key drops, go to WRITE_OUT with fail=1.
  - Neither: hold.
- WAIT_RETRY: the timer decrements each cycle. When it reaches 0, proc_obtain_key=1 with the same key, return to WAIT_ACQ. Re-acquire therefore occurs WAIT_CYCLES+1 cycles after the blocked cycle.
- WRITE_OUT: while full=1, hold with wrreq=0 and data stable. Once full=0, pulse wrreq with {fail, ch, entry}, then go to IDLE. The next arbitration happens no earlier than the cycle after wrreq.
- The retry counter is wide enough for MAX_RETRIES. With MAX_RETRIES=0 it saturates and never triggers fail.
- Other channels' FIFOs are untouched while one channel is in service.

Optional Feature:
- Macro: LOCK_KEY_ARB_STATS_EN.
- Defined: the block adds input stats_clr and 32-bit outputs stat_grants, stat_blocks and stat_fails.
  - Each counter increments once per grant, blocked response, or fail write respectively.
  - Counters saturate at all-ones and are zeroed by reset or by stats_clr. If stats_clr and an event coincide, the counter clears.
- Undefined: the block has no such ports and no counter logic.

Decomposition:
- Package lock_key_pkg holds the state enum typedef, a clog2-with-min-1 function, and the OUT_WIDTH field-offset constants (FAIL_BIT, CH_LSB).
- Sub-module lock_key_rr_arb: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: valid, index.
  - Kept separate so it is reusable and unit-testable; the rest stays in one FSM module.

Test Plan:
- Single grant: ch2 holds entry with key 0xDEADBEEF; grant asserted 2 cycles after obtain. Required: rdreq=4'b0100 at T+1, proc_key=0xDEADBEEF at T+3, then one wrreq with fail=0, ch=2 and the entry unchanged.
- Round-robin fairness: all 4 channels non-empty with 2 entries each, immediate grants. Required service order 0,1,2,3,0,1,2,3.
- Backoff: blocked once, then grant. Required: proc_obtain_key low exactly WAIT_CYCLES cycles (20) between the two attempts, and one output write with fail=0.
- Retry exhaustion: MAX_RETRIES=2, blocked always. Required: exactly 3 obtain attempts, then wrreq with fail=1; with stats enabled, stat_blocks=3 and stat_fails=1.
- Backpressure and gating:
  - locks_available=0 with non-empty FIFOs: no rdreq.
  - Output full for 10 cycles after a grant: wrreq stays low and data is stable, and exactly one wrreq follows release.
- Async reset mid-WAIT_RETRY: assert reset between clock edges. Required: all outputs 0 immediately, and after release the block restarts arbitration at channel 0.

Source files
------------

// File: rtl/lock_key_pkg.sv
// Shared types and helpers for the multi-channel lock-key arbiter.
package lock_key_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReadFifo,
        StParse,
        StWaitAcq,
        StWriteOut,
        StWaitRetry
    } lock_state_e;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Output word layout: {fail, channel, entry}.
    function automatic int unsigned ch_lsb_of(input int unsigned entry_width);
        return entry_width;
    endfunction

    function automatic int unsigned fail_bit_of(input int unsigned entry_width,
                                                input int unsigned ch_width);
        return entry_width + ch_width;
    endfunction

endpackage

// File: rtl/lock_key_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module lock_key_rr_arb #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        valid = 1'b0;
        index = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr) + off) % N;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/lock_key_arb.sv
// Round-robin lock acquirer over NUM_CHANNELS request FIFOs with bounded retry/backoff.
// Optional event counters are enabled by defining LOCK_KEY_ARB_STATS_EN.
module lock_key_arb
    import lock_key_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned ENTRY_WIDTH  = 65,
    parameter int unsigned KEY_LSB      = 32,
    parameter int unsigned KEY_WIDTH    = 32,
    parameter int unsigned WAIT_CYCLES  = 20,
    parameter int unsigned MAX_RETRIES  = 7,
    localparam int unsigned CH_W        = clog2_min1(NUM_CHANNELS),
    localparam int unsigned OUT_WIDTH   = ENTRY_WIDTH + 1 + CH_W
) (
    input  logic                                clk,
    input  logic                                reset,
`ifdef LOCK_KEY_ARB_STATS_EN
    input  logic                                stats_clr,
    output logic [31:0]                         stat_grants,
    output logic [31:0]                         stat_blocks,
    output logic [31:0]                         stat_fails,
`endif
    input  logic [NUM_CHANNELS*ENTRY_WIDTH-1:0] gen_lock_fifo_q,
    input  logic [NUM_CHANNELS-1:0]             gen_lock_fifo_empty,
    output logic [NUM_CHANNELS-1:0]             gen_lock_fifo_rdreq,
    output logic [OUT_WIDTH-1:0]                lock_read_fifo_data,
    input  logic                                lock_read_fifo_full,
    output logic                                lock_read_fifo_wrreq,
    output logic [KEY_WIDTH-1:0]                proc_key,
    output logic                                proc_obtain_key,
    input  logic                                proc_key_grant,
    input  logic                                proc_key_blocked,
    input  logic                                locks_available
);

    localparam int unsigned CH_LSB   = ch_lsb_of(ENTRY_WIDTH);
    localparam int unsigned FAIL_BIT = fail_bit_of(ENTRY_WIDTH, CH_W);
    localparam int unsigned RETRY_W  = clog2_min1(MAX_RETRIES + 1);
    localparam int unsigned TIMER_W  = clog2_min1(WAIT_CYCLES + 1);

    lock_state_e            state_q;
    logic [CH_W-1:0]        rr_ptr_q;
    logic [CH_W-1:0]        ch_q;
    logic [ENTRY_WIDTH-1:0] entry_q;
    logic [TIMER_W-1:0]     timer_q;
    logic [RETRY_W-1:0]     retry_q;

    logic                    pick_valid;
    logic [CH_W-1:0]         pick_idx;
    logic [CH_W-1:0]         next_ptr;
    logic [ENTRY_WIDTH-1:0]  cur_entry;
    logic [OUT_WIDTH-1:0]    out_word;
    logic                    retries_exhausted;

    lock_key_rr_arb #(
        .N     (NUM_CHANNELS),
        .IDX_W (CH_W)
    ) u_rr_arb (
        .req   (~gen_lock_fifo_empty),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_comb begin
        next_ptr = (pick_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : pick_idx + 1'b1;
        // Non-show-ahead FIFO: the slice is valid the cycle after rdreq.
        cur_entry = gen_lock_fifo_q[ch_q*ENTRY_WIDTH +: ENTRY_WIDTH];
        out_word = '0;
        out_word[CH_LSB +: CH_W] = ch_q;
        out_word[ENTRY_WIDTH-1:0] = entry_q;
        retries_exhausted = (MAX_RETRIES != 0) && (retry_q == RETRY_W'(MAX_RETRIES));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q              <= StIdle;
            rr_ptr_q             <= '0;
            ch_q                 <= '0;
            entry_q              <= '0;
            timer_q              <= '0;
            retry_q              <= '0;
            gen_lock_fifo_rdreq  <= '0;
            lock_read_fifo_data  <= '0;
            lock_read_fifo_wrreq <= 1'b0;
            proc_key             <= '0;
            proc_obtain_key      <= 1'b0;
        end else begin
            gen_lock_fifo_rdreq  <= '0;
            lock_read_fifo_wrreq <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Skip the cycle that carries the previous write pulse.
                    if (pick_valid && locks_available && !lock_read_fifo_wrreq) begin
                        ch_q                <= pick_idx;
                        rr_ptr_q            <= next_ptr;
                        gen_lock_fifo_rdreq <= NUM_CHANNELS'(1) << pick_idx;
                        state_q             <= StReadFifo;
                    end
                end
                StReadFifo: state_q <= StParse;
                StParse: begin
                    entry_q         <= cur_entry;
                    proc_key        <= cur_entry[KEY_LSB +: KEY_WIDTH];
                    proc_obtain_key <= 1'b1;
                    retry_q         <= '0;
                    state_q         <= StWaitAcq;
                end
                StWaitAcq: begin
                    if (proc_key_grant) begin
                        proc_obtain_key     <= 1'b0;
                        retry_q             <= '0;
                        lock_read_fifo_data <= out_word;
                        state_q             <= StWriteOut;
                    end else if (proc_key_blocked) begin
                        proc_obtain_key <= 1'b0;
                        if (retries_exhausted) begin
                            retry_q             <= '0;
                            lock_read_fifo_data <= out_word | (OUT_WIDTH'(1) << FAIL_BIT);
                            state_q             <= StWriteOut;
                        end else begin
                            timer_q <= TIMER_W'(WAIT_CYCLES);
                            if (retry_q != '1) begin
                                retry_q <= retry_q + 1'b1;
                            end
                            state_q <= StWaitRetry;
                        end
                    end
                end
                StWriteOut: begin
                    if (!lock_read_fifo_full) begin
                        lock_read_fifo_wrreq <= 1'b1;
                        state_q              <= StIdle;
                    end
                end
                StWaitRetry: begin
                    timer_q <= timer_q - 1'b1;
                    if (timer_q == TIMER_W'(1)) begin
                        proc_obtain_key <= 1'b1;
                        state_q         <= StWaitAcq;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef LOCK_KEY_ARB_STATS_EN
    logic ev_grant;
    logic ev_block;
    logic ev_fail;

    always_comb begin
        ev_grant = (state_q == StWaitAcq) && proc_key_grant;
        ev_block = (state_q == StWaitAcq) && proc_key_blocked && !proc_key_grant;
        ev_fail  = (state_q == StWriteOut) && !lock_read_fifo_full &&
                   lock_read_fifo_data[FAIL_BIT];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_grants <= '0;
            stat_blocks <= '0;
            stat_fails  <= '0;
        end else if (stats_clr) begin
            stat_grants <= '0;
            stat_blocks <= '0;
            stat_fails  <= '0;
        end else begin
            if (ev_grant && stat_grants != '1) stat_grants <= stat_grants + 1'b1;
            if (ev_block && stat_blocks != '1) stat_blocks <= stat_blocks + 1'b1;
            if (ev_fail && stat_fails != '1) stat_fails <= stat_fails + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lock_key_arb.sv
// Directed bench for lock_key_arb with a non-show-ahead FIFO model per channel.
module tb_lock_key_arb;

    localparam int unsigned NCH = 4;
    localparam int unsigned EW  = 65;
    localparam int unsigned KW  = 32;
    localparam int unsigned OW  = 68;

    logic                clk = 1'b0;
    logic                reset;
    logic [NCH*EW-1:0]   fifo_q;
    logic [NCH-1:0]      fifo_empty;
    logic [NCH-1:0]      rdreq;
    logic [OW-1:0]       data;
    logic                full;
    logic                wrreq;
    logic [KW-1:0]       key;
    logic                obtain;
    logic                grant;
    logic                blocked;
    logic                locks;
`ifdef LOCK_KEY_ARB_STATS_EN
    logic                stats_clr;
    logic [31:0]         stat_grants;
    logic [31:0]         stat_blocks;
    logic [31:0]         stat_fails;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    lock_key_arb #(
        .NUM_CHANNELS (NCH),
        .ENTRY_WIDTH  (EW),
        .KEY_LSB      (32),
        .KEY_WIDTH    (KW),
        .WAIT_CYCLES  (20),
        .MAX_RETRIES  (2)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
`ifdef LOCK_KEY_ARB_STATS_EN
        .stats_clr            (stats_clr),
        .stat_grants          (stat_grants),
        .stat_blocks          (stat_blocks),
        .stat_fails           (stat_fails),
`endif
        .gen_lock_fifo_q      (fifo_q),
        .gen_lock_fifo_empty  (fifo_empty),
        .gen_lock_fifo_rdreq  (rdreq),
        .lock_read_fifo_data  (data),
        .lock_read_fifo_full  (full),
        .lock_read_fifo_wrreq (wrreq),
        .proc_key             (key),
        .proc_obtain_key      (obtain),
        .proc_key_grant       (grant),
        .proc_key_blocked     (blocked),
        .locks_available      (locks)
    );

    // FIFO model: the bench pushes, the read side pops on rdreq.
    logic [EW-1:0] mem [NCH][8];
    int unsigned   wr_cnt [NCH] = '{default: 0};
    int unsigned   rd_cnt [NCH] = '{default: 0};
    logic [EW-1:0] q_reg  [NCH] = '{default: '0};

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            fifo_empty[i]         = (rd_cnt[i] == wr_cnt[i]);
            fifo_q[i*EW +: EW]    = q_reg[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rdreq[i] && rd_cnt[i] != wr_cnt[i]) begin
                q_reg[i]  <= mem[i][rd_cnt[i] % 8];
                rd_cnt[i] <= rd_cnt[i] + 1;
            end
        end
    end

    // Output-write log and obtain-attempt counter.
    logic [OW-1:0] wr_log [$];
    int unsigned   obtain_rises = 0;
    logic          obtain_prev = 1'b0;

    always @(negedge clk) begin
        if (wrreq) wr_log.push_back(data);
        if (obtain && !obtain_prev) obtain_rises <= obtain_rises + 1;
        obtain_prev <= obtain;
    end

    task automatic push(input int ch, input logic [EW-1:0] e);
        mem[ch][wr_cnt[ch] % 8] = e;
        wr_cnt[ch] = wr_cnt[ch] + 1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_obtain(input string tag, input int budget);
        int n = 0;
        while (!obtain && n < budget) begin
            step();
            n++;
        end
        chk(tag, obtain, 1'b1);
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        int n = 0;
        while (wr_log.size() < target && n < budget) begin
            step();
            n++;
        end
        chk(tag, wr_log.size() >= target, 1'b1);
    endtask

    function automatic logic [EW-1:0] mk_entry(input int ch, input int idx);
        logic [31:0] k;
        logic [31:0] lo;
        k  = 32'hA000_0000 + 32'(ch * 16 + idx);
        lo = 32'h5555_0000 + 32'(ch * 16 + idx);
        return {1'b0, k, lo};
    endfunction

    function automatic logic [OW-1:0] mk_out(input logic f, input int ch, input logic [EW-1:0] e);
        logic [1:0] c;
        c = 2'(ch);
        return {f, c, e};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [EW-1:0] e1, e3, e4, e5a, e5b, e6a, e6b;
        int            base;
        int            rbase;
        int            lows;
        int            bad;
        int            wcount;

        reset = 1'b0; full = 1'b0; grant = 1'b0; blocked = 1'b0; locks = 1'b1;
`ifdef LOCK_KEY_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) step();
        chk("rst_rdreq", rdreq, '0);
        chk("rst_wrreq", wrreq, 1'b0);
        chk("rst_obtain", obtain, 1'b0);
        chk("rst_key", key, '0);
        chk("rst_data", data, '0);
        reset = 1'b1;

        // Single grant on channel 2.
        e1 = {1'b1, 32'hDEAD_BEEF, 32'h1234_5678};
        push(2, e1);
        step(); chk("t1_rdreq", rdreq, 4'b0100);
        step(); chk("t1_rdreq_pulse", rdreq, 4'b0000);
        step(); chk("t1_key", key, 32'hDEAD_BEEF);
        chk("t1_obtain", obtain, 1'b1);
        step(); chk("t1_obtain_hold", obtain, 1'b1);
        step(); grant = 1'b1;
        step(); grant = 1'b0; chk("t1_obtain_drop", obtain, 1'b0);
        step(); chk("t1_wrreq", wrreq, 1'b1);
        chk("t1_data", data, mk_out(1'b0, 2, e1));
        step(); chk("t1_wrreq_pulse", wrreq, 1'b0);
        chk("t1_write_count", wr_log.size(), 1);

        // Round-robin fairness from a fresh pointer.
        reset = 1'b0; step(); reset = 1'b1;
        base = wr_log.size();
        for (int idx = 0; idx < 2; idx++)
            for (int ch = 0; ch < 4; ch++) push(ch, mk_entry(ch, idx));
        grant = 1'b1;
        wait_writes("t2_done", base + 8, 400);
        for (int k = 0; k < 8; k++) begin
            if (wr_log.size() > base + k)
                chk($sformatf("t2_order%0d", k), wr_log[base + k],
                    mk_out(1'b0, k % 4, mk_entry(k % 4, k / 4)));
        end
        grant = 1'b0;

        // Blocked once, then granted after the backoff.
        base = wr_log.size();
        e3 = {1'b0, 32'hCAFE_0003, 32'h0000_0333};
        push(0, e3);
        wait_obtain("t3_first", 40);
        blocked = 1'b1;
        step(); blocked = 1'b0;
        chk("t3_drop", obtain, 1'b0);
        lows = 1;
        while (!obtain && lows < 100) begin
            step();
            if (!obtain) lows++;
        end
        chk("t3_backoff_low", lows, 20);
        chk("t3_same_key", key, 32'hCAFE_0003);
        grant = 1'b1;
        step(); grant = 1'b0;
        wait_writes("t3_write", base + 1, 10);
        if (wr_log.size() > base) chk("t3_data", wr_log[base], mk_out(1'b0, 0, e3));

        // Retry exhaustion with MAX_RETRIES=2.
`ifdef LOCK_KEY_ARB_STATS_EN
        stats_clr = 1'b1; step(); stats_clr = 1'b0;
`endif
        base = wr_log.size();
        rbase = obtain_rises;
        e4 = {1'b1, 32'hBAD0_0004, 32'h0000_0444};
        push(1, e4);
        blocked = 1'b1;
        wait_writes("t4_write", base + 1, 200);
        blocked = 1'b0;
        chk("t4_attempts", obtain_rises - rbase, 3);
        if (wr_log.size() > base) chk("t4_data", wr_log[base], mk_out(1'b1, 1, e4));
`ifdef LOCK_KEY_ARB_STATS_EN
        chk("t4_stat_blocks", stat_blocks, 32'd3);
        chk("t4_stat_fails", stat_fails, 32'd1);
        chk("t4_stat_grants", stat_grants, 32'd0);
`endif

        // No arbitration while the lock unit is full.
        locks = 1'b0;
        e5a = {1'b0, 32'h5A5A_0002, 32'h0000_0552};
        e5b = {1'b0, 32'h5B5B_0003, 32'h0000_0553};
        push(2, e5a);
        push(3, e5b);
        bad = 0;
        repeat (10) begin
            step();
            if (rdreq != '0) bad++;
        end
        chk("t5_no_rdreq", bad, 0);

        // Output backpressure after a grant.
        full = 1'b1; grant = 1'b1; locks = 1'b1;
        base = wr_log.size();
        wait_obtain("t5_obtain", 20);
        step(); grant = 1'b0;
        chk("t5_obtain_drop", obtain, 1'b0);
        chk("t5_hold_data", data, mk_out(1'b0, 2, e5a));
        bad = 0;
        repeat (10) begin
            if (wrreq || data !== mk_out(1'b0, 2, e5a)) bad++;
            step();
        end
        chk("t5_hold_stable", bad, 0);
        full = 1'b0;
        wcount = 0;
        repeat (6) begin
            step();
            if (wrreq) wcount++;
        end
        chk("t5_one_write", wcount, 1);

        // Async reset while channel 3 is backing off.
        wait_obtain("t6_obtain", 20);
        chk("t6_key", key, 32'h5B5B_0003);
        blocked = 1'b1;
        step(); blocked = 1'b0;
        chk("t6_in_retry", obtain, 1'b0);
        step(); step();
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_rdreq", rdreq, '0);
        chk("t6_rst_wrreq", wrreq, 1'b0);
        chk("t6_rst_obtain", obtain, 1'b0);
        chk("t6_rst_key", key, '0);
        chk("t6_rst_data", data, '0);
        step();
        e6a = {1'b0, 32'h6A6A_0000, 32'h0000_0660};
        e6b = {1'b0, 32'h6B6B_0003, 32'h0000_0663};
        push(3, e6b);
        push(0, e6a);
        base = wr_log.size();
        step(); reset = 1'b1;
        step(); chk("t6_restart_ch0", rdreq, 4'b0001);
        grant = 1'b1;
        wait_writes("t6_writes", base + 2, 80);
        grant = 1'b0;
        if (wr_log.size() > base + 1) begin
            chk("t6_first", wr_log[base], mk_out(1'b0, 0, e6a));
            chk("t6_second", wr_log[base + 1], mk_out(1'b0, 3, e6b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
